// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flush, memory freeze and ALU operand forwarding.
// Optional feature macro HAZARD_FWD_EN: when defined, forwarding is enabled; when undefined, every RAW hazard stalls instead.
module hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int PERF_W   = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [REG_AW-1:0] i_ifid_rs1,
  input  logic [REG_AW-1:0] i_ifid_rs2,
  input  logic              i_ifid_use_rs1,
  input  logic              i_ifid_use_rs2,
  input  logic [REG_AW-1:0] i_idex_rs1,
  input  logic [REG_AW-1:0] i_idex_rs2,
  input  logic [REG_AW-1:0] i_idex_rd,
  input  logic              i_idex_reg_write,
  input  logic              i_idex_mem_to_reg,
  input  logic [REG_AW-1:0] i_exmem_rd,
  input  logic              i_exmem_reg_write,
  input  logic [REG_AW-1:0] i_memwb_rd,
  input  logic              i_memwb_reg_write,
  input  logic              i_branch_taken,
  input  logic              i_mem_busy,
  output logic              o_stall_if,
  output logic              o_stall_id,
  output logic              o_bubble_ex,
  output logic              o_flush_id,
  output logic              o_freeze,
  output logic [1:0]        o_fwd_a,
  output logic [1:0]        o_fwd_b,
  output logic [1:0]        o_state,
  output logic [PERF_W-1:0] o_stall_cycles
);

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    LOAD_STALL = 2'b01,
    MEM_WAIT   = 2'b10
  } state_t;

  localparam logic [2:0] LAT_M1 = 3'(LOAD_LAT - 1);

  state_t            state_r, state_n, saved_r, saved_n;
  logic [2:0]        cnt_r, cnt_n;
  logic [PERF_W-1:0] perf_r;
  logic              load_hz, raw_hz;
  logic [1:0]        fwd_a, fwd_b;

  // Writer-to-source match; register 0 is hard-wired and never a dependency.
  function automatic logic dep(input logic wr, input logic [REG_AW-1:0] rd,
                               input logic [REG_AW-1:0] src);
    return wr && (rd != {REG_AW{1'b0}}) && (rd == src);
  endfunction

  always_comb begin
    load_hz = i_idex_mem_to_reg &&
              ((i_ifid_use_rs1 && dep(i_idex_reg_write, i_idex_rd, i_ifid_rs1)) ||
               (i_ifid_use_rs2 && dep(i_idex_reg_write, i_idex_rd, i_ifid_rs2)));
  end

`ifdef HAZARD_FWD_EN
  // EX/MEM wins over MEM/WB because it holds the younger result.
  always_comb begin
    raw_hz = 1'b0;
    fwd_a  = 2'b00;
    fwd_b  = 2'b00;
    if (dep(i_exmem_reg_write, i_exmem_rd, i_idex_rs1)) begin
      fwd_a = 2'b01;
    end else if (dep(i_memwb_reg_write, i_memwb_rd, i_idex_rs1)) begin
      fwd_a = 2'b10;
    end else begin
      fwd_a = 2'b00;
    end
    if (dep(i_exmem_reg_write, i_exmem_rd, i_idex_rs2)) begin
      fwd_b = 2'b01;
    end else if (dep(i_memwb_reg_write, i_memwb_rd, i_idex_rs2)) begin
      fwd_b = 2'b10;
    end else begin
      fwd_b = 2'b00;
    end
  end
`else
  logic unused_fwd_srcs;
  assign unused_fwd_srcs = ^{i_idex_rs1, i_idex_rs2};

  // Without bypass paths any in-flight writer of a used source stalls decode.
  always_comb begin
    fwd_a  = 2'b00;
    fwd_b  = 2'b00;
    raw_hz = (i_ifid_use_rs1 && (dep(i_idex_reg_write, i_idex_rd, i_ifid_rs1) ||
                                 dep(i_exmem_reg_write, i_exmem_rd, i_ifid_rs1) ||
                                 dep(i_memwb_reg_write, i_memwb_rd, i_ifid_rs1))) ||
             (i_ifid_use_rs2 && (dep(i_idex_reg_write, i_idex_rd, i_ifid_rs2) ||
                                 dep(i_exmem_reg_write, i_exmem_rd, i_ifid_rs2) ||
                                 dep(i_memwb_reg_write, i_memwb_rd, i_ifid_rs2)));
  end
`endif

  // Priority: reset, memory freeze, branch flush, then per-state stall handling.
  always_comb begin
    o_stall_if  = 1'b0;
    o_stall_id  = 1'b0;
    o_bubble_ex = 1'b0;
    o_flush_id  = 1'b0;
    o_freeze    = 1'b0;
    o_fwd_a     = 2'b00;
    o_fwd_b     = 2'b00;
    state_n     = state_r;
    saved_n     = saved_r;
    cnt_n       = cnt_r;
    if (i_rst) begin
      state_n = RUN;
      saved_n = RUN;
      cnt_n   = 3'd0;
    end else if (i_mem_busy) begin
      o_freeze = 1'b1;
      state_n  = MEM_WAIT;
      if (state_r != MEM_WAIT) begin
        saved_n = state_r;
      end else begin
        saved_n = saved_r;
      end
    end else if (i_branch_taken) begin
      o_fwd_a     = fwd_a;
      o_fwd_b     = fwd_b;
      o_flush_id  = 1'b1;
      o_bubble_ex = 1'b1;
      cnt_n       = 3'd0;
      state_n     = RUN;
    end else begin
      o_fwd_a = fwd_a;
      o_fwd_b = fwd_b;
      case (state_r)
        MEM_WAIT: begin
          state_n = saved_r;
        end
        LOAD_STALL: begin
          o_stall_if  = 1'b1;
          o_stall_id  = 1'b1;
          o_bubble_ex = 1'b1;
          cnt_n       = cnt_r - 3'd1;
          if (cnt_r <= 3'd1) begin
            state_n = RUN;
          end else begin
            state_n = LOAD_STALL;
          end
        end
        default: begin
          state_n = RUN;
          if (load_hz || raw_hz) begin
            o_stall_if  = 1'b1;
            o_stall_id  = 1'b1;
            o_bubble_ex = 1'b1;
            if (load_hz && (LOAD_LAT > 1)) begin
              state_n = LOAD_STALL;
              cnt_n   = LAT_M1;
            end else begin
              state_n = RUN;
            end
          end else begin
            state_n = RUN;
          end
        end
      endcase
    end
  end

  // State, remaining-bubble counter, pre-freeze state and saturating stall counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= RUN;
      saved_r <= RUN;
      cnt_r   <= 3'd0;
      perf_r  <= {PERF_W{1'b0}};
    end else begin
      state_r <= state_n;
      saved_r <= saved_n;
      cnt_r   <= cnt_n;
      if ((o_stall_id || o_freeze) && (perf_r != {PERF_W{1'b1}})) begin
        perf_r <= perf_r + PERF_W'(1);
      end
    end
  end

  assign o_state        = state_r;
  assign o_stall_cycles = perf_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: vector table plus multi-cycle stall/freeze/reset sequences.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] ifid_rs1, ifid_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd;
  logic       use_rs1, use_rs2, idex_wr, idex_m2r, exmem_wr, memwb_wr, branch, busy;

  logic       s_if, s_id, bub, fl, frz;
  logic [1:0] fa, fb, st;
  logic [15:0] perf;
  logic       t_if, t_id, t_bub, t_fl, t_frz;
  logic [1:0] t_fa, t_fb, t_st;
  logic [1:0] t_perf;
  logic [4:0] ctrl;

  int n_chk  = 0;
  int n_fail = 0;

  assign ctrl = {s_if, s_id, bub, fl, frz};

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(5), .LOAD_LAT(2), .PERF_W(16)) u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_ifid_rs1(ifid_rs1), .i_ifid_rs2(ifid_rs2),
    .i_ifid_use_rs1(use_rs1), .i_ifid_use_rs2(use_rs2),
    .i_idex_rs1(idex_rs1), .i_idex_rs2(idex_rs2), .i_idex_rd(idex_rd),
    .i_idex_reg_write(idex_wr), .i_idex_mem_to_reg(idex_m2r),
    .i_exmem_rd(exmem_rd), .i_exmem_reg_write(exmem_wr),
    .i_memwb_rd(memwb_rd), .i_memwb_reg_write(memwb_wr),
    .i_branch_taken(branch), .i_mem_busy(busy),
    .o_stall_if(s_if), .o_stall_id(s_id), .o_bubble_ex(bub), .o_flush_id(fl),
    .o_freeze(frz), .o_fwd_a(fa), .o_fwd_b(fb), .o_state(st), .o_stall_cycles(perf)
  );

  hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .PERF_W(2)) u_sat (
    .i_clk(clk), .i_rst(rst),
    .i_ifid_rs1(ifid_rs1), .i_ifid_rs2(ifid_rs2),
    .i_ifid_use_rs1(use_rs1), .i_ifid_use_rs2(use_rs2),
    .i_idex_rs1(idex_rs1), .i_idex_rs2(idex_rs2), .i_idex_rd(idex_rd),
    .i_idex_reg_write(idex_wr), .i_idex_mem_to_reg(idex_m2r),
    .i_exmem_rd(exmem_rd), .i_exmem_reg_write(exmem_wr),
    .i_memwb_rd(memwb_rd), .i_memwb_reg_write(memwb_wr),
    .i_branch_taken(branch), .i_mem_busy(busy),
    .o_stall_if(t_if), .o_stall_id(t_id), .o_bubble_ex(t_bub), .o_flush_id(t_fl),
    .o_freeze(t_frz), .o_fwd_a(t_fa), .o_fwd_b(t_fb), .o_state(t_st), .o_stall_cycles(t_perf)
  );

  typedef struct {
    logic       m2r;  logic       iwr;  logic [4:0] ird;  logic [4:0] irs1; logic [4:0] irs2;
    logic [4:0] frs1; logic       fu1;  logic [4:0] frs2; logic       fu2;
    logic [4:0] xrd;  logic       xwr;  logic [4:0] wrd;  logic       wwr;  logic       br;
    logic [4:0] e_ctrl;  // {stall_if, stall_id, bubble, flush, freeze} with forwarding
    logic [3:0] e_fwd;   // {fwd_a, fwd_b} with forwarding
    logic       e_raw;   // decode source has an in-flight writer
    logic [1:0] e_state; // o_state after the edge (LOAD_LAT=2 instance)
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    ifid_rs1 = 5'd0; ifid_rs2 = 5'd0; use_rs1 = 1'b0; use_rs2 = 1'b0;
    idex_rs1 = 5'd0; idex_rs2 = 5'd0; idex_rd = 5'd0; idex_wr = 1'b0; idex_m2r = 1'b0;
    exmem_rd = 5'd0; exmem_wr = 1'b0; memwb_rd = 5'd0; memwb_wr = 1'b0;
    branch = 1'b0; busy = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic load_x5();
    idex_m2r = 1'b1; idex_wr = 1'b1; idex_rd = 5'd5; ifid_rs1 = 5'd5; use_rs1 = 1'b1;
  endtask

  initial begin
    logic [4:0] exp_ctrl;
    logic [3:0] exp_fwd;

    //            m2r   iwr   ird    irs1   irs2   frs1   fu1   frs2   fu2   xrd    xwr   wrd    wwr   br    ctrl       fwd      raw   state
    vecs[0]  = '{1'b0, 1'b0, 5'd0, 5'd0,  5'd0,  5'd0, 1'b0, 5'd0,  1'b0, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 5'b00000, 4'b0000, 1'b0, 2'b00};
    vecs[1]  = '{1'b1, 1'b1, 5'd0, 5'd0,  5'd0,  5'd0, 1'b1, 5'd0,  1'b0, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 5'b00000, 4'b0000, 1'b0, 2'b00};
    vecs[2]  = '{1'b0, 1'b0, 5'd0, 5'd7,  5'd3,  5'd0, 1'b0, 5'd0,  1'b0, 5'd3, 1'b1, 5'd3,  1'b1, 1'b0, 5'b00000, 4'b0001, 1'b0, 2'b00};
    vecs[3]  = '{1'b0, 1'b0, 5'd0, 5'd7,  5'd3,  5'd0, 1'b0, 5'd0,  1'b0, 5'd3, 1'b0, 5'd3,  1'b1, 1'b0, 5'b00000, 4'b0010, 1'b0, 2'b00};
    vecs[4]  = '{1'b0, 1'b0, 5'd0, 5'd4,  5'd6,  5'd0, 1'b0, 5'd0,  1'b0, 5'd4, 1'b1, 5'd6,  1'b1, 1'b0, 5'b00000, 4'b0110, 1'b0, 2'b00};
    vecs[5]  = '{1'b0, 1'b0, 5'd0, 5'd0,  5'd0,  5'd0, 1'b0, 5'd0,  1'b0, 5'd0, 1'b1, 5'd0,  1'b1, 1'b0, 5'b00000, 4'b0000, 1'b0, 2'b00};
    vecs[6]  = '{1'b1, 1'b1, 5'd5, 5'd0,  5'd0,  5'd5, 1'b1, 5'd0,  1'b0, 5'd0, 1'b0, 5'd0,  1'b0, 1'b1, 5'b00110, 4'b0000, 1'b1, 2'b00};
    vecs[7]  = '{1'b1, 1'b1, 5'd9, 5'd0,  5'd0,  5'd2, 1'b1, 5'd9,  1'b1, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 5'b11100, 4'b0000, 1'b1, 2'b01};
    vecs[8]  = '{1'b1, 1'b1, 5'd9, 5'd0,  5'd0,  5'd2, 1'b1, 5'd9,  1'b0, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 5'b00000, 4'b0000, 1'b0, 2'b00};
    vecs[9]  = '{1'b0, 1'b1, 5'd8, 5'd0,  5'd0,  5'd8, 1'b1, 5'd0,  1'b0, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 5'b00000, 4'b0000, 1'b1, 2'b00};
    vecs[10] = '{1'b0, 1'b0, 5'd0, 5'd0,  5'd12, 5'd0, 1'b0, 5'd12, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0, 5'b00000, 4'b0010, 1'b1, 2'b00};

    clear_inputs();
    rst = 1'b1;
    step();
    step();
    check("reset_ctrl", {27'd0, ctrl}, 32'd0);
    check("reset_fwd", {28'd0, fa, fb}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_state", {30'd0, st}, 32'd0);
    check("reset_perf", {16'd0, perf}, 32'd0);

    for (int i = 0; i < 11; i++) begin
      do_reset();
      idex_m2r = vecs[i].m2r;  idex_wr  = vecs[i].iwr;  idex_rd  = vecs[i].ird;
      idex_rs1 = vecs[i].irs1; idex_rs2 = vecs[i].irs2;
      ifid_rs1 = vecs[i].frs1; use_rs1  = vecs[i].fu1;
      ifid_rs2 = vecs[i].frs2; use_rs2  = vecs[i].fu2;
      exmem_rd = vecs[i].xrd;  exmem_wr = vecs[i].xwr;
      memwb_rd = vecs[i].wrd;  memwb_wr = vecs[i].wwr;
      branch   = vecs[i].br;
`ifdef HAZARD_FWD_EN
      exp_ctrl = vecs[i].e_ctrl;
      exp_fwd  = vecs[i].e_fwd;
`else
      exp_ctrl = (vecs[i].e_raw && !vecs[i].br) ? 5'b11100 : vecs[i].e_ctrl;
      exp_fwd  = 4'b0000;
`endif
      @(negedge clk);
      check($sformatf("vec%0d_ctrl", i), {27'd0, ctrl}, {27'd0, exp_ctrl});
      check($sformatf("vec%0d_fwd", i), {28'd0, fa, fb}, {28'd0, exp_fwd});
      step();
      check($sformatf("vec%0d_state", i), {30'd0, st}, {30'd0, vecs[i].e_state});
      check($sformatf("vec%0d_lat1_state", i), {30'd0, t_st}, 32'd0);
    end

    // Two-cycle load-use stall with LOAD_LAT=2.
    do_reset();
    load_x5();
    @(negedge clk);
    check("lu_c1_ctrl", {27'd0, ctrl}, {27'd0, 5'b11100});
    check("lu_c1_state", {30'd0, st}, 32'd0);
    step();
    check("lu_c2_state", {30'd0, st}, 32'd1);
    @(negedge clk);
    check("lu_c2_ctrl", {27'd0, ctrl}, {27'd0, 5'b11100});
    step();
    check("lu_done_state", {30'd0, st}, 32'd0);
    check("lu_perf", {16'd0, perf}, 32'd2);
    clear_inputs();
    @(negedge clk);
    check("lu_after_ctrl", {27'd0, ctrl}, 32'd0);

    // Freeze for three cycles in the middle of a load stall.
    do_reset();
    load_x5();
    step();
    check("mw_pre_state", {30'd0, st}, 32'd1);
    busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("mw_freeze%0d", k), {27'd0, ctrl}, {27'd0, 5'b00001});
      step();
      check($sformatf("mw_state%0d", k), {30'd0, st}, 32'd2);
    end
    busy = 1'b0;
    @(negedge clk);
    check("mw_release_ctrl", {27'd0, ctrl}, 32'd0);
    step();
    check("mw_resume_state", {30'd0, st}, 32'd1);
    @(negedge clk);
    check("mw_resume_ctrl", {27'd0, ctrl}, {27'd0, 5'b11100});
    step();
    check("mw_end_state", {30'd0, st}, 32'd0);
    check("mw_perf", {16'd0, perf}, 32'd5);
    clear_inputs();

    // Reset while in LOAD_STALL, with a forwarding match present.
    do_reset();
    load_x5();
    idex_rs1 = 5'd5; exmem_rd = 5'd5; exmem_wr = 1'b1;
    step();
    check("rs_pre_state", {30'd0, st}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rs_ctrl", {27'd0, ctrl}, 32'd0);
    check("rs_fwd", {28'd0, fa, fb}, 32'd0);
    step();
    check("rs_state", {30'd0, st}, 32'd0);
    check("rs_perf", {16'd0, perf}, 32'd0);
    rst = 1'b0;
    clear_inputs();

    // Saturation of a 2-bit counter under a held hazard.
    do_reset();
    load_x5();
    step();
    step();
    check("sat_count2", {30'd0, t_perf}, 32'd2);
    step();
    step();
    step();
    check("sat_hold", {30'd0, t_perf}, 32'd3);
    clear_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
